// File: rtl/tinker_mem_pkg.sv
// Shared types and constants for the Tinker memory responder: FSM states,
// port identifiers, access sizes and the range-check helper.
package tinker_mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic PORT_I = 1'b0;
  localparam logic PORT_D = 1'b1;

  localparam int FETCH_BYTES = 4;
  localparam int DATA_BYTES  = 8;

  // Widened to 65 bits so that addresses near 2^64 cannot wrap back into range.
  function automatic logic out_of_range(input logic [63:0] addr,
                                        input logic [31:0] size,
                                        input logic [63:0] mem_bytes);
    return ({1'b0, addr} + {33'b0, size}) > {1'b0, mem_bytes};
  endfunction

endpackage

// File: rtl/tinker_mem_array.sv
// Byte-addressed little-endian storage: combinational 4/8-byte read and a
// registered 8-byte write, both at the same byte address.
module tinker_mem_array
  import tinker_mem_pkg::*;
#(
  parameter int MEM_BYTES = 524288,
  parameter int AW        = $clog2(MEM_BYTES)
) (
  input  logic          clk,
  input  logic [AW-1:0] i_addr,
  input  logic          i_we,
  input  logic [63:0]   i_wdata,
  output logic [31:0]   o_rdata4,
  output logic [63:0]   o_rdata8
);

  // NOTE: storage has no reset; clearing a memory would need a per-entry
  // reset network and the contents are required to survive reset anyway.
  logic [7:0] r_mem [MEM_BYTES];

  always_comb begin
    o_rdata8 = '0;
    for (int k = 0; k < DATA_BYTES; k++) begin
      o_rdata8[8*k +: 8] = r_mem[i_addr + AW'(k)];
    end
  end

  assign o_rdata4 = o_rdata8[8*FETCH_BYTES-1:0];

  always_ff @(posedge clk) begin
    if (i_we) begin
      for (int k = 0; k < DATA_BYTES; k++) begin
        r_mem[i_addr + AW'(k)] <= i_wdata[8*k +: 8];
      end
    end
  end

endmodule

// File: rtl/tinker_mem_responder.sv
// Memory responder for the Tinker fetch and data ports: one outstanding access,
// data port has priority, fixed LATENCY from accept to response-valid.
module tinker_mem_responder
  import tinker_mem_pkg::*;
#(
  parameter int MEM_BYTES = 524288,
  parameter int LATENCY   = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_req_valid,
  output logic        i_req_ready,
  input  logic [63:0] i_req_addr,
  output logic        i_rsp_valid,
  input  logic        i_rsp_ready,
  output logic [31:0] i_rsp_data,
  output logic        i_rsp_err,
  input  logic        d_req_valid,
  output logic        d_req_ready,
  input  logic        d_req_we,
  input  logic [63:0] d_req_addr,
  input  logic [63:0] d_req_wdata,
  output logic        d_rsp_valid,
  input  logic        d_rsp_ready,
  output logic [63:0] d_rsp_rdata,
  output logic        d_rsp_err
);

  localparam int          AW        = $clog2(MEM_BYTES);
  localparam logic [31:0] WAIT_INIT = (LATENCY >= 2) ? 32'(LATENCY - 2) : 32'd0;

  state_t      r_state;
  logic [31:0] r_cnt;
  logic        r_port;
  logic        r_we;
  logic [63:0] r_addr;
  logic [63:0] r_wdata;

  logic        r_i_rsp_valid;
  logic [31:0] r_i_rsp_data;
  logic        r_i_rsp_err;
  logic        r_d_rsp_valid;
  logic [63:0] r_d_rsp_rdata;
  logic        r_d_rsp_err;

  logic        w_d_acc;
  logic        w_i_acc;
  logic        w_hs;
  logic        w_exec;
  logic        w_x_port;
  logic        w_x_we;
  logic [63:0] w_x_addr;
  logic [63:0] w_x_wdata;
  logic        w_x_err;
  logic        w_mem_we;
  logic [31:0] w_rdata4;
  logic [63:0] w_rdata8;

  assign d_req_ready = (r_state == IDLE);
  assign i_req_ready = (r_state == IDLE) && !d_req_valid;
  assign w_d_acc     = d_req_valid && d_req_ready;
  assign w_i_acc     = i_req_valid && i_req_ready;
  assign w_hs        = (r_port == PORT_D) ? (r_d_rsp_valid && d_rsp_ready)
                                          : (r_i_rsp_valid && i_rsp_ready);

  // The access executes on the last WAIT edge, or on the accept edge itself
  // when LATENCY is 1, in which case the request comes straight from the ports.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path
    // leaves a variable unassigned and infers a latch.
    w_exec    = 1'b0;
    w_x_port  = r_port;
    w_x_we    = r_we;
    w_x_addr  = r_addr;
    w_x_wdata = r_wdata;
    if (r_state == WAIT && r_cnt == 32'd0) begin
      w_exec = 1'b1;
    end else if (r_state == IDLE && (w_d_acc || w_i_acc) && LATENCY == 1) begin
      w_exec    = 1'b1;
      w_x_port  = w_d_acc ? PORT_D : PORT_I;
      w_x_we    = w_d_acc && d_req_we;
      w_x_addr  = w_d_acc ? d_req_addr : i_req_addr;
      w_x_wdata = d_req_wdata;
    end
  end

  assign w_x_err  = out_of_range(w_x_addr,
                                 (w_x_port == PORT_D) ? 32'(DATA_BYTES) : 32'(FETCH_BYTES),
                                 64'(MEM_BYTES));
  assign w_mem_we = w_exec && (w_x_port == PORT_D) && w_x_we && !w_x_err && !reset;

  tinker_mem_array #(
    .MEM_BYTES(MEM_BYTES),
    .AW       (AW)
  ) u_array (
    .clk     (clk),
    .i_addr  (w_x_addr[AW-1:0]),
    .i_we    (w_mem_we),
    .i_wdata (w_x_wdata),
    .o_rdata4(w_rdata4),
    .o_rdata8(w_rdata8)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= IDLE;
      r_cnt         <= '0;
      r_port        <= PORT_I;
      r_we          <= 1'b0;
      r_addr        <= '0;
      r_wdata       <= '0;
      r_i_rsp_valid <= 1'b0;
      r_i_rsp_data  <= '0;
      r_i_rsp_err   <= 1'b0;
      r_d_rsp_valid <= 1'b0;
      r_d_rsp_rdata <= '0;
      r_d_rsp_err   <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (w_d_acc || w_i_acc) begin
            r_port  <= w_d_acc ? PORT_D : PORT_I;
            r_we    <= w_d_acc && d_req_we;
            r_addr  <= w_d_acc ? d_req_addr : i_req_addr;
            r_wdata <= d_req_wdata;
            if (LATENCY == 1) begin
              r_state <= RESP;
            end else begin
              r_state <= WAIT;
              r_cnt   <= WAIT_INIT;
            end
          end
        end
        WAIT: begin
          if (r_cnt == 32'd0) r_state <= RESP;
          else                r_cnt   <= r_cnt - 32'd1;
        end
        RESP: begin
          if (w_hs) begin
            r_state       <= IDLE;
            r_i_rsp_valid <= 1'b0;
            r_d_rsp_valid <= 1'b0;
          end
        end
        default: r_state <= IDLE;
      endcase

      if (w_exec) begin
        if (w_x_port == PORT_D) begin
          r_d_rsp_valid <= 1'b1;
          r_d_rsp_rdata <= (w_x_we || w_x_err) ? 64'd0 : w_rdata8;
          r_d_rsp_err   <= w_x_err;
        end else begin
          r_i_rsp_valid <= 1'b1;
          r_i_rsp_data  <= w_x_err ? 32'd0 : w_rdata4;
          r_i_rsp_err   <= w_x_err;
        end
      end
    end
  end

  assign i_rsp_valid = r_i_rsp_valid;
  assign i_rsp_data  = r_i_rsp_data;
  assign i_rsp_err   = r_i_rsp_err;
  assign d_rsp_valid = r_d_rsp_valid;
  assign d_rsp_rdata = r_d_rsp_rdata;
  assign d_rsp_err   = r_d_rsp_err;

endmodule

// File: tb/tb_tinker_mem_responder.sv
// Bench for tinker_mem_responder: a LATENCY=2 and a LATENCY=3 instance share
// request inputs; the one not under test is held in reset.
module tb_tinker_mem_responder;

  localparam int MEM_BYTES = 524288;
  localparam int LOW_END   = 'h2100;
  localparam int TOP_START = 'h7FF00;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset2, reset3, sel3;
  logic        i_req_valid, i_rsp_ready;
  logic [63:0] i_req_addr;
  logic        d_req_valid, d_req_we, d_rsp_ready;
  logic [63:0] d_req_addr, d_req_wdata;

  logic        i_req_ready_2, i_rsp_valid_2, i_rsp_err_2, d_req_ready_2, d_rsp_valid_2, d_rsp_err_2;
  logic [31:0] i_rsp_data_2;
  logic [63:0] d_rsp_rdata_2;
  logic        i_req_ready_3, i_rsp_valid_3, i_rsp_err_3, d_req_ready_3, d_rsp_valid_3, d_rsp_err_3;
  logic [31:0] i_rsp_data_3;
  logic [63:0] d_rsp_rdata_3;

  tinker_mem_responder #(.MEM_BYTES(MEM_BYTES), .LATENCY(2)) u_dut2 (
    .clk(clk), .reset(reset2),
    .i_req_valid(i_req_valid), .i_req_ready(i_req_ready_2), .i_req_addr(i_req_addr),
    .i_rsp_valid(i_rsp_valid_2), .i_rsp_ready(i_rsp_ready), .i_rsp_data(i_rsp_data_2),
    .i_rsp_err(i_rsp_err_2),
    .d_req_valid(d_req_valid), .d_req_ready(d_req_ready_2), .d_req_we(d_req_we),
    .d_req_addr(d_req_addr), .d_req_wdata(d_req_wdata),
    .d_rsp_valid(d_rsp_valid_2), .d_rsp_ready(d_rsp_ready), .d_rsp_rdata(d_rsp_rdata_2),
    .d_rsp_err(d_rsp_err_2)
  );

  tinker_mem_responder #(.MEM_BYTES(MEM_BYTES), .LATENCY(3)) u_dut3 (
    .clk(clk), .reset(reset3),
    .i_req_valid(i_req_valid), .i_req_ready(i_req_ready_3), .i_req_addr(i_req_addr),
    .i_rsp_valid(i_rsp_valid_3), .i_rsp_ready(i_rsp_ready), .i_rsp_data(i_rsp_data_3),
    .i_rsp_err(i_rsp_err_3),
    .d_req_valid(d_req_valid), .d_req_ready(d_req_ready_3), .d_req_we(d_req_we),
    .d_req_addr(d_req_addr), .d_req_wdata(d_req_wdata),
    .d_rsp_valid(d_rsp_valid_3), .d_rsp_ready(d_rsp_ready), .d_rsp_rdata(d_rsp_rdata_3),
    .d_rsp_err(d_rsp_err_3)
  );

  logic        o_i_req_ready, o_i_rsp_valid, o_i_rsp_err, o_d_req_ready, o_d_rsp_valid, o_d_rsp_err;
  logic [31:0] o_i_rsp_data;
  logic [63:0] o_d_rsp_rdata;
  assign o_i_req_ready = sel3 ? i_req_ready_3 : i_req_ready_2;
  assign o_i_rsp_valid = sel3 ? i_rsp_valid_3 : i_rsp_valid_2;
  assign o_i_rsp_err   = sel3 ? i_rsp_err_3   : i_rsp_err_2;
  assign o_i_rsp_data  = sel3 ? i_rsp_data_3  : i_rsp_data_2;
  assign o_d_req_ready = sel3 ? d_req_ready_3 : d_req_ready_2;
  assign o_d_rsp_valid = sel3 ? d_rsp_valid_3 : d_rsp_valid_2;
  assign o_d_rsp_err   = sel3 ? d_rsp_err_3   : d_rsp_err_2;
  assign o_d_rsp_rdata = sel3 ? d_rsp_rdata_3 : d_rsp_rdata_2;

  int         checks = 0;
  int         errors = 0;
  int         cur_lat;
  logic [7:0] mm [MEM_BYTES];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference model: plain byte array, range rule addr+n <= MEM_BYTES.
  function automatic logic m_err(input logic [63:0] a, input int n);
    return a > 64'(MEM_BYTES - n);
  endfunction

  function automatic logic [63:0] m_read(input logic [63:0] a, input int n);
    logic [63:0] v = '0;
    if (m_err(a, n)) return '0;
    for (int k = 0; k < n; k++) v[8*k +: 8] = mm[int'(a) + k];
    return v;
  endfunction

  task automatic m_write(input logic [63:0] a, input logic [63:0] d);
    for (int k = 0; k < 8; k++) mm[int'(a) + k] = d[8*k +: 8];
  endtask

  // Called at a negedge; returns at the negedge after the accept edge.
  task automatic issue(input bit port, input bit we, input logic [63:0] a,
                       input logic [63:0] wd, output int waits);
    if (port) begin
      d_req_valid = 1'b1; d_req_we = we; d_req_addr = a; d_req_wdata = wd;
    end else begin
      i_req_valid = 1'b1; i_req_addr = a;
    end
    waits = 0;
    #1;
    while (!(port ? o_d_req_ready : o_i_req_ready) && waits < 50) begin
      @(negedge clk); #1; waits++;
    end
    if (waits >= 50) check("accept_timeout", 64'(waits), 64'd0);
    @(posedge clk);
    @(negedge clk);
    if (port) d_req_valid = 1'b0;
    else      i_req_valid = 1'b0;
  endtask

  task automatic respond(input bit port, input bit we, input logic [63:0] a, input int hold);
    int          lat = 1;
    int          n = port ? 8 : 4;
    logic [63:0] exp_data = (port && we) ? 64'd0 : m_read(a, n);
    logic        exp_err  = m_err(a, n);
    while (!(port ? o_d_rsp_valid : o_i_rsp_valid) && lat < 50) begin
      @(negedge clk); lat++;
    end
    check("rsp_latency", 64'(lat), 64'(cur_lat));
    check("rsp_data", port ? o_d_rsp_rdata : {32'd0, o_i_rsp_data}, exp_data);
    check("rsp_err", {63'd0, port ? o_d_rsp_err : o_i_rsp_err}, {63'd0, exp_err});
    check("other_valid", {63'd0, port ? o_i_rsp_valid : o_d_rsp_valid}, 64'd0);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check("hold_valid", {63'd0, port ? o_d_rsp_valid : o_i_rsp_valid}, 64'd1);
      check("hold_data", port ? o_d_rsp_rdata : {32'd0, o_i_rsp_data}, exp_data);
      check("hold_req_ready", {62'd0, o_i_req_ready, o_d_req_ready}, 64'd0);
    end
    if (port) d_rsp_ready = 1'b1;
    else      i_rsp_ready = 1'b1;
    @(negedge clk);
    d_rsp_ready = 1'b0;
    i_rsp_ready = 1'b0;
    check("post_hs_valid", {63'd0, port ? o_d_rsp_valid : o_i_rsp_valid}, 64'd0);
    check("post_hs_d_ready", {63'd0, o_d_req_ready}, 64'd1);
  endtask

  task automatic access(input bit port, input bit we, input logic [63:0] a,
                        input logic [63:0] wd, input int hold);
    int w;
    issue(port, we, a, wd, w);
    respond(port, we, a, hold);
    if (port && we && !m_err(a, 8)) m_write(a, wd);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int          w;
    logic [63:0] a;
    bit          port, we;

    sel3 = 1'b0; reset2 = 1'b1; reset3 = 1'b1; cur_lat = 2;
    i_req_valid = 1'b0; i_req_addr = '0; i_rsp_ready = 1'b0;
    d_req_valid = 1'b0; d_req_we = 1'b0; d_req_addr = '0; d_req_wdata = '0; d_rsp_ready = 1'b0;
    repeat (3) @(negedge clk);
    reset2 = 1'b0;
    @(negedge clk);
    check("rst_i_rsp_valid", {63'd0, o_i_rsp_valid}, 64'd0);
    check("rst_d_rsp_valid", {63'd0, o_d_rsp_valid}, 64'd0);
    check("rst_rsp_err", {62'd0, o_i_rsp_err, o_d_rsp_err}, 64'd0);
    check("rst_i_rsp_data", {32'd0, o_i_rsp_data}, 64'd0);
    check("rst_d_rsp_rdata", o_d_rsp_rdata, 64'd0);
    check("rst_req_ready", {62'd0, o_i_req_ready, o_d_req_ready}, 64'd3);

    // Give the regions used below known contents.
    for (int i = 0; i < LOW_END; i += 8) access(1, 1, 64'(i), {$urandom, $urandom}, 0);
    for (int i = TOP_START; i < MEM_BYTES; i += 8) access(1, 1, 64'(i), {$urandom, $urandom}, 0);

    // Store, load and two fetches of the same word.
    access(1, 1, 64'h100, 64'h1122334455667788, 0);
    access(1, 0, 64'h100, 64'd0, 0);
    access(0, 0, 64'h100, 64'd0, 0);
    access(0, 0, 64'h104, 64'd0, 0);

    // Simultaneous requests: data first, fetch right after its handshake.
    d_req_valid = 1'b1; d_req_we = 1'b0; d_req_addr = 64'h100;
    i_req_valid = 1'b1; i_req_addr = 64'h104;
    #1;
    check("both_valid_i_ready", {63'd0, o_i_req_ready}, 64'd0);
    check("both_valid_d_ready", {63'd0, o_d_req_ready}, 64'd1);
    issue(1, 0, 64'h100, 64'd0, w);
    check("d_first_wait", 64'(w), 64'd0);
    respond(1, 0, 64'h100, 0);
    issue(0, 0, 64'h104, 64'd0, w);
    check("fetch_after_hs_wait", 64'(w), 64'd0);
    respond(0, 0, 64'h104, 0);

    // Back-pressure on a load response.
    access(1, 0, 64'h108, 64'd0, 5);

    // Top-of-memory range checks.
    access(1, 0, 64'h7FFFC, 64'd0, 0);
    access(0, 0, 64'h7FFFC, 64'd0, 0);
    access(1, 1, 64'h7FFF9, 64'hDEADBEEFDEADBEEF, 0);
    access(1, 0, 64'h7FFF8, 64'd0, 0);
    access(0, 0, 64'hFFFF_FFFF_FFFF_FFFE, 64'd0, 0);

    // Unaligned store and overlapping fetch.
    access(1, 1, 64'h2003, 64'hA1B2C3D4E5F60718, 1);
    access(1, 0, 64'h2003, 64'd0, 0);
    access(0, 0, 64'h2000, 64'd0, 0);

    // Randomized traffic against the byte-array model.
    repeat (200) begin
      port = 1'($urandom_range(0, 1));
      we   = port && ($urandom_range(0, 1) == 1);
      case ($urandom_range(0, 9))
        0, 1, 2, 3, 4, 5, 6: a = 64'($urandom_range(0, LOW_END - 8));
        7, 8:                a = 64'(TOP_START + $urandom_range(0, 255));
        default:             a = {$urandom, $urandom};
      endcase
      access(port, we, a, {$urandom, $urandom}, $urandom_range(0, 2));
    end

    // LATENCY=3 instance: reset during WAIT must drop the store.
    reset2 = 1'b1; sel3 = 1'b1; cur_lat = 3;
    reset3 = 1'b0;
    @(negedge clk);
    access(1, 1, 64'h300, 64'hCAFEF00D12345678, 0);
    issue(1, 1, 64'h300, 64'h0BADBEEF0BADBEEF, w);
    reset3 = 1'b1;
    @(negedge clk);
    check("mid_rst_d_valid", {63'd0, o_d_rsp_valid}, 64'd0);
    check("mid_rst_d_rdata", o_d_rsp_rdata, 64'd0);
    reset3 = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check("dropped_no_rsp", {62'd0, o_i_rsp_valid, o_d_rsp_valid}, 64'd0);
    end
    access(1, 0, 64'h300, 64'd0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/tinker_mem_responder.md
Name: tinker_mem_responder

Overview:
Memory-side responder for the Tinker core's instruction-fetch and data ports. It holds a byte-addressed, little-endian unified memory (instructions and data share it) and serves requests over valid/ready handshakes with a fixed, parameterised latency. The core acts as initiator on both ports. This block arbitrates between the ports, sequences each access through a small FSM, and returns fetch words, load data and store acknowledgements.

Parameters:
MEM_BYTES, 524288, memory size in bytes; legal addresses are 0..MEM_BYTES-1
LATENCY, 2, cycles from request accept to first response-valid cycle; must be >= 1

Ports:
clk  in  1  clock, all state updates on rising edge
reset  in  1  synchronous, active-high reset
i_req_valid  in  1  fetch request valid
i_req_ready  out  1  fetch request accepted when valid&&ready
i_req_addr  in  64  fetch byte address
i_rsp_valid  out  1  fetch response valid
i_rsp_ready  in  1  core accepts fetch response
i_rsp_data  out  32  fetched instruction, bytes addr..addr+3, little-endian
i_rsp_err  out  1  fetch out of range
d_req_valid  in  1  data request valid
d_req_ready  out  1  data request accepted when valid&&ready
d_req_we  in  1  1 = store, 0 = load
d_req_addr  in  64  data byte address
d_req_wdata  in  64  store data
d_rsp_valid  out  1  data response valid (load data or store ack)
d_rsp_ready  in  1  core accepts data response
d_rsp_rdata  out  64  load data, bytes addr..addr+7, little-endian; 0 for stores
d_rsp_err  out  1  access out of range

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous, active-high, on port reset.
- Outstanding requests: one at a time across both ports.
- FSM states:
  - IDLE: accepts a request.
  - WAIT: counts LATENCY-1 cycles.
  - RESP: presents the response.
- Request ready (combinational from state and valids):
  - d_req_ready = (state==IDLE).
  - i_req_ready = (state==IDLE) && !d_req_valid.
  - The data port has fixed priority because it carries the older instruction.
- Accept, at edge E when valid&&ready: latch port id, we, addr, wdata.
  - LATENCY==1: next state RESP.
  - Otherwise: next state WAIT with counter = LATENCY-2.
- WAIT:
  - Counter decrements each cycle.
  - At counter==0, next state RESP.
  - In the same edge, the access executes: read data is captured into the response register, or the store is committed to memory.
- Response timing: rsp_valid is first high in the cycle after edge E+LATENCY-1, i.e. visible from edge E+LATENCY.
- RESP:
  - Holds rsp_valid, data and err stable while the matching rsp_ready is low.
  - On rsp_valid&&rsp_ready, returns to IDLE.
  - A new request can be accepted in the cycle after the handshake; there is no same-cycle overlap.
- Range check: err=1 when addr+size > MEM_BYTES, with size 4 for fetch and 8 for data. Compute in 65-bit to avoid wrap. On error:
  - no memory write;
  - response data = 0;
  - the response is still given with normal latency.
- Alignment: none required; any byte address within range is legal.
- Store ack: d_rsp_rdata = 0, err per range check.
- A store committed at edge X is visible to any request accepted after edge X.
- Reset values and reset mid-operation:
  - state=IDLE; counter=0.
  - i_rsp_valid, d_rsp_valid, i_rsp_err, d_rsp_err = 0; i_rsp_data, d_rsp_rdata = 0.
  - Any pending request is dropped with no response.
  - An uncommitted store (reset before the commit edge) never writes.
  - Memory contents are not cleared by reset.
- Request inputs when ready=0, and rsp_ready when rsp_valid=0, are ignored.

Decomposition:
- Package tinker_mem_pkg holds:
  - FSM state enum (IDLE, WAIT, RESP);
  - port-id constants PORT_I=0, PORT_D=1;
  - size constants FETCH_BYTES=4, DATA_BYTES=8.
- Sub-module tinker_mem_array is the byte storage:
  - MEM_BYTES entries;
  - 4-byte and 8-byte little-endian combinational read;
  - registered 8-byte write with enable.
- The FSM, arbitration and response registers stay in tinker_mem_responder.

Test Plan:
1. Reset, LATENCY=2; store addr 0x100, data 0x1122334455667788, d_rsp_ready=1 -> d_rsp_valid high 2 cycles after accept, rdata 0, err 0. Load 0x100 -> 0x1122334455667788. Fetch 0x100 -> 0x55667788; fetch 0x104 -> 0x11223344.
2. i_req_valid and d_req_valid both raised in IDLE -> i_req_ready=0 and the data request is accepted. The fetch is accepted the cycle after the d_rsp handshake completes.
3. Load response with d_rsp_ready held low 5 cycles -> d_rsp_valid and rdata stable for all 5 cycles, both req_ready low. The handshake on cycle 6 returns the FSM to IDLE.
4. Load 0x7FFFC -> d_rsp_err=1, rdata 0. Fetch 0x7FFFC -> err 0, valid data. Store 0x7FFF9 -> err 1, and a re-read of bytes 0x7FFF9..0x7FFFF shows them unchanged.
5. Store accepted, reset asserted during WAIT (LATENCY=3) -> no d_rsp_valid, and a later load of that address returns the prior contents.
6. Unaligned store 0x2003 = 0xA1B2C3D4E5F60718, then load 0x2003 returns the same value. Fetch 0x2000 -> 0x18000000 | prior bytes 0x2000..0x2002.
